// File: rtl/board_select.sv
// -----------------------------------------------------------------------------
// board_select
//
// Cursor-driven piece/destination selector for the chess screen of one player
// station. A player whose turn it is walks a cursor over the board, picks one of
// its own pieces, walks to a destination and raises a move request towards the
// move validator. While a destination is being chosen the displayed board is a
// preview with the picked piece lifted from its source and dropped under the
// cursor.
//
// Optional feature (compile-time macro):
//   BOARD_SELECT_RESELECT_EN - when defined, pressing enter on another own piece
//   while choosing a destination re-picks that piece. When undefined, the same
//   action aborts the selection and returns to IDLE.
//
// Parameters:
//   BOARD_DIM   board edge length in squares (2..16)
//   PIECE_W     piece-code width in bits
//   EMPTY_CODE  code of an empty square
//   OWN_SPLIT   codes below this belong to player 1, other non-empty to player 0
//   WRAP        1 = cursor wraps at the board edge, 0 = cursor clamps
//
// Ports:
//   CLOCK_50      in   sole clock, rising edge
//   reset_n       in   synchronous active-low reset
//   active        in   chess screen shown; 0 freezes FSM, cursor and display
//   player        in   player identity of this station
//   curr_player   in   player whose turn it is
//   dir           in   cursor axis: 1 = row, 0 = column
//   key_dec/inc   in   one-cycle cursor step pulses (dec wins when both)
//   key_ent       in   one-cycle select pulse
//   key_cancel    in   one-cycle cancel pulse
//   stable_board  in   committed board, square (r,c) at (r*BOARD_DIM+c)*PIECE_W
//   disp_board    out  board to display (same layout)
//   cursor_hl     out  one-hot cursor square, bit r*BOARD_DIM+c
//   source_hl     out  one-hot source square, bit r*BOARD_DIM+c
//   move_valid    out  move request pending
//   move_ack      in   validator consumed the request
//   move_packet   out  {src_r, src_c, dst_r, dst_c}
//   fsm_state     out  IDLE=0, PIECE_SEL=1, POS_SEL=2, MOVE_REQ=3
// -----------------------------------------------------------------------------
module board_select #(
  parameter int BOARD_DIM  = 8,
  parameter int PIECE_W    = 4,
  parameter int EMPTY_CODE = 15,
  parameter int OWN_SPLIT  = 6,
  parameter int WRAP       = 1
) (
  input  logic                                   CLOCK_50,
  input  logic                                   reset_n,
  input  logic                                   active,
  input  logic                                   player,
  input  logic                                   curr_player,
  input  logic                                   dir,
  input  logic                                   key_dec,
  input  logic                                   key_inc,
  input  logic                                   key_ent,
  input  logic                                   key_cancel,
  input  logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] stable_board,
  output logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] disp_board,
  output logic [BOARD_DIM*BOARD_DIM-1:0]         cursor_hl,
  output logic [BOARD_DIM*BOARD_DIM-1:0]         source_hl,
  output logic                                   move_valid,
  input  logic                                   move_ack,
  output logic [4*$clog2(BOARD_DIM)-1:0]         move_packet,
  output logic [1:0]                             fsm_state
);

  localparam int CW  = $clog2(BOARD_DIM);
  localparam int NSQ = BOARD_DIM * BOARD_DIM;
  localparam int BW  = NSQ * PIECE_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PIECE_SEL = 2'd1;
  localparam logic [1:0] POS_SEL   = 2'd2;
  localparam logic [1:0] MOVE_REQ  = 2'd3;

  localparam logic [CW-1:0]      CENTER = CW'(BOARD_DIM / 2 - 1);
  localparam logic [CW-1:0]      LAST   = CW'(BOARD_DIM - 1);
  localparam logic [PIECE_W-1:0] EMPTY  = PIECE_W'(EMPTY_CODE);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Code of a square in the standard 8x8 starting position. Back rows use the
  // piece order rook, knight, bishop, queen, king, bishop, knight, rook.
  function automatic logic [PIECE_W-1:0] home_code(input int r, input int c);
    int back;
    case (c)
      0, 7:    back = 0;
      1, 6:    back = 1;
      2, 5:    back = 2;
      default: back = c;
    endcase
    case (r)
      0:       return PIECE_W'(back + 6);
      1:       return PIECE_W'(11);
      6:       return PIECE_W'(5);
      7:       return PIECE_W'(back);
      default: return EMPTY;
    endcase
  endfunction

  // Display content right after reset: the starting position on an 8x8 board,
  // an all-empty board for any other size.
  function automatic logic [BW-1:0] init_board();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < BOARD_DIM; r++) begin
      for (int c = 0; c < BOARD_DIM; c++) begin
        if (BOARD_DIM == 8) b[(r*BOARD_DIM+c)*PIECE_W +: PIECE_W] = home_code(r, c);
        else                b[(r*BOARD_DIM+c)*PIECE_W +: PIECE_W] = EMPTY;
      end
    end
    return b;
  endfunction

  localparam logic [BW-1:0] INIT_BOARD = init_board();

  function automatic int sq_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return int'(r) * BOARD_DIM + int'(c);
  endfunction

  // One cursor step along an axis; the edge either wraps or clamps.
  function automatic logic [CW-1:0] step(input logic [CW-1:0] pos, input logic dec);
    if (dec) begin
      if (pos == '0) return (WRAP != 0) ? LAST : '0;
      return pos - CW'(1);
    end
    if (pos == LAST) return (WRAP != 0) ? '0 : LAST;
    return pos + CW'(1);
  endfunction

  function automatic logic is_own(input logic [PIECE_W-1:0] code, input logic who);
    if (code == EMPTY) return 1'b0;
    if (who)           return int'(code) <  OWN_SPLIT;
    return int'(code) >= OWN_SPLIT;
  endfunction

  // Board with the source square emptied and the code dropped on the target.
  // The target write wins, so hovering over the source shows the piece there.
  function automatic logic [BW-1:0] preview(input logic [BW-1:0]      base,
                                            input int                 s_idx,
                                            input int                 t_idx,
                                            input logic [PIECE_W-1:0] code);
    logic [BW-1:0] b;
    b = base;
    for (int i = 0; i < NSQ; i++) begin
      if (i == t_idx)      b[i*PIECE_W +: PIECE_W] = code;
      else if (i == s_idx) b[i*PIECE_W +: PIECE_W] = EMPTY;
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q,    state_d;
  logic [CW-1:0]      cur_r_q,    cur_r_d;
  logic [CW-1:0]      cur_c_q,    cur_c_d;
  logic [CW-1:0]      src_r_q,    src_r_d;
  logic [CW-1:0]      src_c_q,    src_c_d;
  logic [CW-1:0]      dst_r_q,    dst_r_d;
  logic [CW-1:0]      dst_c_q,    dst_c_d;
  logic [PIECE_W-1:0] src_code_q, src_code_d;
  logic [BW-1:0]      disp_q,     disp_d;

  logic [PIECE_W-1:0] cur_code;
  logic               cur_own;
  int                 cur_idx;
  int                 src_idx;

  assign cur_idx = sq_idx(cur_r_q, cur_c_q);
  assign src_idx = sq_idx(src_r_q, src_c_q);

  // Piece under the registered cursor. Enter always acts on this square, so a
  // cursor step in the same cycle never changes what gets selected.
  always_comb begin
    cur_code = EMPTY;
    for (int i = 0; i < NSQ; i++) begin
      if (i == cur_idx) cur_code = stable_board[i*PIECE_W +: PIECE_W];
    end
  end

  assign cur_own = is_own(cur_code, player);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here first gets a hold default, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cur_r_d    = cur_r_q;
    cur_c_d    = cur_c_q;
    src_r_d    = src_r_q;
    src_c_d    = src_c_q;
    dst_r_d    = dst_r_q;
    dst_c_d    = dst_c_q;
    src_code_d = src_code_q;
    disp_d     = disp_q;

    // Cursor moves only while a square is being chosen.
    if (active && (state_q == PIECE_SEL || state_q == POS_SEL) && (key_dec || key_inc)) begin
      if (dir) cur_r_d = step(cur_r_q, key_dec);
      else     cur_c_d = step(cur_c_q, key_dec);
    end

    case (state_q)
      IDLE: begin
        if (active && player == curr_player) begin
          state_d = PIECE_SEL;
          cur_r_d = CENTER;
          cur_c_d = CENTER;
        end
      end

      PIECE_SEL: begin
        if (active && key_ent && cur_own) begin
          state_d    = POS_SEL;
          src_r_d    = cur_r_q;
          src_c_d    = cur_c_q;
          src_code_d = cur_code;
        end
      end

      POS_SEL: begin
        if (active) begin
          if (key_cancel) begin
            state_d = PIECE_SEL;
            src_r_d = '0;
            src_c_d = '0;
          end else if (key_ent) begin
            if (cur_own) begin
`ifdef BOARD_SELECT_RESELECT_EN
              src_r_d    = cur_r_q;
              src_c_d    = cur_c_q;
              src_code_d = cur_code;
`else
              state_d = IDLE;
`endif
            end else begin
              state_d = MOVE_REQ;
              dst_r_d = cur_r_q;
              dst_c_d = cur_c_q;
            end
          end
        end
      end

      // The handshake completes even while the screen is inactive.
      MOVE_REQ: begin
        if (move_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // The display follows the state being entered so the preview tracks the
    // cursor without a cycle of lag. The preview is frozen on entry to
    // MOVE_REQ and held until the request completes.
    if (active) begin
      case (state_d)
        POS_SEL: disp_d = preview(stable_board, sq_idx(src_r_d, src_c_d),
                                  sq_idx(cur_r_d, cur_c_d), src_code_d);
        MOVE_REQ: begin
          if (state_q != MOVE_REQ)
            disp_d = preview(stable_board, sq_idx(src_r_d, src_c_d),
                             sq_idx(dst_r_d, dst_c_d), src_code_d);
        end
        default: disp_d = stable_board;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_r_q    <= CENTER;
      cur_c_q    <= CENTER;
      src_r_q    <= '0;
      src_c_q    <= '0;
      dst_r_q    <= '0;
      dst_c_q    <= '0;
      src_code_q <= EMPTY;
      // NOTE: the display copy is a bank of flops, not a RAM, so it can take a
      // reset value like any other register.
      disp_q     <= INIT_BOARD;
    end else begin
      state_q    <= state_d;
      cur_r_q    <= cur_r_d;
      cur_c_q    <= cur_c_d;
      src_r_q    <= src_r_d;
      src_c_q    <= src_c_d;
      dst_r_q    <= dst_r_d;
      dst_c_q    <= dst_c_d;
      src_code_q <= src_code_d;
      disp_q     <= disp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from registers)
  // ---------------------------------------------------------------------------
  assign disp_board  = disp_q;
  assign fsm_state   = state_q;
  // Source and destination only change outside MOVE_REQ, so the packet is
  // stable for the whole request.
  assign move_valid  = (state_q == MOVE_REQ);
  assign move_packet = {src_r_q, src_c_q, dst_r_q, dst_c_q};

  always_comb begin
    cursor_hl = '0;
    source_hl = '0;
    for (int i = 0; i < NSQ; i++) begin
      if ((state_q == PIECE_SEL || state_q == POS_SEL) && i == cur_idx) cursor_hl[i] = 1'b1;
      if ((state_q == POS_SEL || state_q == MOVE_REQ) && i == src_idx)  source_hl[i] = 1'b1;
    end
  end

endmodule

// File: doc/board_select.md
BOARD_SELECT -- requirements
Module: board_select

Interface
REQ-001 BOARD_DIM, 8, board edge length in squares (2..16); CW = $clog2(BOARD_DIM).
REQ-002 PIECE_W, 4, piece-code width in bits.
REQ-003 EMPTY_CODE, 15, piece code for an empty square.
REQ-004 OWN_SPLIT, 6, codes < OWN_SPLIT belong to player 1; other non-empty codes belong to player 0.
REQ-005 WRAP, 1, cursor behaviour at the board edge: 1 = wrap modulo BOARD_DIM, 0 = clamp.
REQ-006 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 active  in  1  the chess screen is shown; when it is 0, the FSM, cursor and outputs hold their values.
REQ-009 player, curr_player  in  1 each  player identity of this station, and the player whose turn it is.
REQ-010 dir  in  1  cursor axis: 1 = row, 0 = column.
REQ-011 key_dec, key_inc, key_ent, key_cancel  in  1 each  one-cycle debounced key pulses.
REQ-012 stable_board  in  BOARD_DIM*BOARD_DIM*PIECE_W  committed board; square (r,c) is at bits [(r*BOARD_DIM+c)*PIECE_W +: PIECE_W].
REQ-013 disp_board  out  same width and layout  board to display.
REQ-014 cursor_hl, source_hl  out  BOARD_DIM*BOARD_DIM each  one-hot square highlights, bit index r*BOARD_DIM+c.
REQ-015 move_valid  out  1  a move request is pending.
REQ-016 move_ack  in  1  the validator has consumed the request.
REQ-017 move_packet  out  4*CW  {src_r, src_c, dst_r, dst_c}.
REQ-018 fsm_state  out  2  debug: IDLE=0, PIECE_SEL=1, POS_SEL=2, MOVE_REQ=3.

Function
REQ-019 IDLE: the block shall register stable_board into disp_board every cycle, and shall go to PIECE_SEL with the cursor at (BOARD_DIM/2-1, BOARD_DIM/2-1) when player==curr_player.
REQ-020 Cursor movement (PIECE_SEL and POS_SEL only): key_dec moves the axis selected by dir by -1 and key_inc by +1; key_dec wins if both pulse in the same cycle; the edge behaviour follows WRAP.
REQ-021 key_ent shall be evaluated at the cursor position held before any movement that occurs in the same cycle.
REQ-022 PIECE_SEL: key_ent on a square owned by player shall latch src=cursor and the source code, and go to POS_SEL; on an empty or opponent square it shall be ignored; key_cancel shall be ignored.
REQ-023 POS_SEL: disp_board shall be the preview, i.e. stable_board with src=EMPTY_CODE and cursor=source code, with the cursor write taking priority.
REQ-024 POS_SEL: key_ent on an empty or opponent square shall latch dst=cursor, freeze the preview into disp_board, and go to MOVE_REQ.
REQ-025 POS_SEL: key_ent on an own square (including src itself) shall be handled as defined in the Configuration section.
REQ-026 POS_SEL: key_cancel shall return to PIECE_SEL with src cleared and disp_board=stable_board on the next cycle; if key_ent and key_cancel pulse together, key_cancel wins.
REQ-027 MOVE_REQ: move_valid=1 and move_packet shall stay stable until move_ack is sampled high; on that cycle move_valid shall deassert on the next edge and the state shall become IDLE.
REQ-028 MOVE_REQ: cursor keys, key_ent and key_cancel shall be ignored.
REQ-029 move_ack outside MOVE_REQ shall be ignored.
REQ-030 cursor_hl shall be one-hot at the cursor only in PIECE_SEL and POS_SEL, else zero; source_hl shall be one-hot at src only in POS_SEL and MOVE_REQ, else zero; both are combinational from registers.
REQ-031 active=0 during MOVE_REQ shall hold move_valid, and move_ack shall still be honoured.

Reset
REQ-032 While reset_n=0 at a clock edge: state=IDLE, cursor=(BOARD_DIM/2-1, BOARD_DIM/2-1), src=dst=0, move_valid=0, move_packet=0.
REQ-033 Reset disp_board: for BOARD_DIM==8, rows 0/7 = {6,7,8,9,10,8,7,6} / {0,1,2,3,4,2,1,0}, row 1 = 11, row 6 = 5, other rows EMPTY_CODE; for any other BOARD_DIM, all squares EMPTY_CODE.
REQ-034 Reset mid-operation shall drop any pending request with no handshake.

Configuration
REQ-035 BOARD_SELECT_RESELECT_EN defined: key_ent on an own square in POS_SEL shall re-latch src and the source code at the cursor and stay in POS_SEL.
REQ-036 BOARD_SELECT_RESELECT_EN undefined: key_ent on an own square in POS_SEL shall go to IDLE, which aborts the selection.

Verification
REQ-037 Reset, BOARD_DIM=8 -> disp_board matches the initial layout, fsm_state=0, cursor (3,3), move_valid=0.
REQ-038 player=curr_player=1, dir=1, key_dec x3 -> cursor (0,3); one more key_dec -> (7,3) with WRAP=1, (0,3) with WRAP=0.
REQ-039 Select a piece at (6,4) code 5, move to (4,4), key_ent -> move_valid=1, move_packet={6,4,4,4}, disp_board[4][4]=5, disp_board[6][4]=15; hold move_ack=0 for 10 cycles -> outputs unchanged; move_ack=1 -> IDLE, move_valid=0.
REQ-040 In POS_SEL, key_ent and key_cancel in the same cycle -> PIECE_SEL, disp_board=stable_board, no request issued.
REQ-041 In POS_SEL, key_ent on own piece (7,1) -> with the macro, src=(7,1), state stays POS_SEL; without it, state=IDLE.
REQ-042 active=0 while key pulses arrive in PIECE_SEL -> cursor and state unchanged; reset_n=0 during MOVE_REQ -> move_valid=0 on the next edge.
